// File: rtl/div_repeated_sub.sv
// Serial-load unsigned divider that uses repeated subtraction. The controller FSM and the A/B/Q datapath share one module.
// Optional macro DIV_ZERO_FLAG_EN adds a sticky div_by_zero output that is cleared on DONE->IDLE.
module div_repeated_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             div_by_zero
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_SUB,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] q_reg;
    logic             busy_reg;
    logic             done_reg;

    // The compare comes before the subtract, so A can never wrap below zero
    logic             a_ge_b;
    logic [WIDTH-1:0] a_minus_b;
    logic [WIDTH-1:0] q_plus_one;

    assign a_ge_b     = (a_reg >= b_reg);
    assign a_minus_b  = a_reg - b_reg;
    assign q_plus_one = q_reg + WIDTH'(1);

`ifdef DIV_ZERO_FLAG_EN
    logic dz_reg;
    assign div_by_zero = dz_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            q_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dz_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_LOAD_A;
                        busy_reg  <= 1'b1;
                    end
                end
                S_LOAD_A: begin
                    a_reg     <= data_in;
                    state_reg <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    b_reg <= data_in;
                    if (data_in == '0) begin
                        // On a zero divisor, A keeps the dividend and Q saturates to all-ones
                        q_reg     <= '1;
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                        dz_reg    <= 1'b1;
`endif
                    end else begin
                        q_reg     <= '0;
                        state_reg <= S_SUB;
                    end
                end
                S_SUB: begin
                    if (a_ge_b) begin
                        a_reg <= a_minus_b;
                        q_reg <= q_plus_one;
                    end else begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // start must be released before another operation can begin
                    if (!start) begin
                        state_reg <= S_IDLE;
                        done_reg  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                        dz_reg    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign quotient  = q_reg;
    assign remainder = a_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
